// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM states and the
// transaction-owner encoding used by the arbiter and its round-robin core.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester arbiter: round-robin on conflict when RR_EN is set,
// otherwise the data side (req[1]) always wins.
module rr_arb2
  import mem_port_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  owner_t last_grant;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= INST;
    end else if (update && (grant != 2'b00)) begin
      last_grant <= owner_t'(grant[1]);
    end
  end

  // NOTE: grant gets a default first so no path through the case can infer a latch.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (RR_EN && (last_grant == DATA)) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access: one
// transaction at a time, with the read response routed back to its owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RR_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req_valid,
  output logic                inst_req_ready,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_req_ack,
  output logic [DATA_W-1:0]   read_data,
  output logic                read_data_valid,
  input  logic                read_data_ready,
  output logic                port_req_valid,
  input  logic                port_req_ready,
  output logic [ADDR_W-1:0]   port_addr,
  output logic                port_wen,
  output logic [DATA_W-1:0]   port_wdata,
  output logic [DATA_W/8-1:0] port_wstrb,
  input  logic                port_resp_valid,
  output logic                port_resp_ready,
  input  logic [DATA_W-1:0]   port_rdata,
  output logic [31:0]         conflict_cnt
);

  state_t     state, state_nxt;
  owner_t     owner;
  logic       inst_pend, data_pend, grant_fire;
  logic [1:0] grant;

  assign inst_pend  = inst_req_valid;
  assign data_pend  = mem_read | mem_write;
  assign grant_fire = (state == IDLE) && (inst_pend || data_pend);

  rr_arb2 #(
    .RR_EN (RR_EN != 0)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({data_pend, inst_pend}),
    .update (grant_fire),
    .grant  (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= INST;
      port_addr    <= '0;
      port_wen     <= 1'b0;
      port_wdata   <= '0;
      port_wstrb   <= '0;
      conflict_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && inst_pend && data_pend) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
      if (grant_fire) begin
        owner <= owner_t'(grant[1]);
        if (grant[1]) begin
          // A simultaneous read+write is treated as a write.
          port_addr  <= mem_addr;
          port_wen   <= mem_write;
          port_wdata <= mem_write ? mem_wdata : '0;
          port_wstrb <= mem_write ? mem_wstrb : '0;
        end else begin
          port_addr  <= inst_addr;
          port_wen   <= 1'b0;
          port_wdata <= '0;
          port_wstrb <= '0;
        end
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    port_req_valid  = 1'b0;
    inst_req_ready  = 1'b0;
    mem_req_ack     = 1'b0;
    inst_valid      = 1'b0;
    inst_rdata      = '0;
    read_data_valid = 1'b0;
    read_data       = '0;
    port_resp_ready = 1'b0;
    case (state)
      IDLE: begin
        if (grant_fire) state_nxt = REQ;
      end
      REQ: begin
        port_req_valid = 1'b1;
        if (owner == INST) inst_req_ready = port_req_ready;
        else               mem_req_ack    = port_req_ready;
        if (port_req_ready) state_nxt = port_wen ? IDLE : RESP;
      end
      RESP: begin
        // Only the owner sees the response; the other side stays quiet.
        if (owner == INST) begin
          inst_valid      = port_resp_valid;
          inst_rdata      = port_rdata;
          port_resp_ready = inst_ready;
        end else begin
          read_data_valid = port_resp_valid;
          read_data       = port_rdata;
          port_resp_ready = read_data_ready;
        end
        if (port_resp_valid && port_resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model plus bench-side memory,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

  localparam int RR = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req_valid, inst_req_ready, inst_valid, inst_ready;
  logic [31:0] inst_addr, inst_rdata;
  logic        mem_read, mem_write, mem_req_ack, read_data_valid, read_data_ready;
  logic [31:0] mem_addr, mem_wdata, read_data;
  logic [3:0]  mem_wstrb;
  logic        port_req_valid, port_req_ready, port_wen, port_resp_valid, port_resp_ready;
  logic [31:0] port_addr, port_wdata, port_rdata, conflict_cnt;
  logic [3:0]  port_wstrb;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(RR)) dut (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .inst_addr(inst_addr),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_rdata(inst_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_req_ack(mem_req_ack), .read_data(read_data),
    .read_data_valid(read_data_valid), .read_data_ready(read_data_ready),
    .port_req_valid(port_req_valid), .port_req_ready(port_req_ready), .port_addr(port_addr),
    .port_wen(port_wen), .port_wdata(port_wdata), .port_wstrb(port_wstrb),
    .port_resp_valid(port_resp_valid), .port_resp_ready(port_resp_ready),
    .port_rdata(port_rdata), .conflict_cnt(conflict_cnt)
  );

  // Fixed-priority instance under permanent conflict.
  logic        f_rst;
  logic        f_inst_req_ready, f_inst_valid, f_mem_req_ack, f_read_data_valid;
  logic        f_port_req_valid, f_port_wen, f_port_resp_ready;
  logic [31:0] f_inst_rdata, f_read_data, f_port_addr, f_port_wdata, f_conflict_cnt;
  logic [3:0]  f_port_wstrb;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0)) dut_fix (
    .clk(clk), .rst(f_rst),
    .inst_req_valid(1'b1), .inst_req_ready(f_inst_req_ready), .inst_addr(32'h0000_0100),
    .inst_valid(f_inst_valid), .inst_ready(1'b1), .inst_rdata(f_inst_rdata),
    .mem_read(1'b1), .mem_write(1'b0), .mem_addr(32'h0000_0200), .mem_wdata(32'h0),
    .mem_wstrb(4'h0), .mem_req_ack(f_mem_req_ack), .read_data(f_read_data),
    .read_data_valid(f_read_data_valid), .read_data_ready(1'b1),
    .port_req_valid(f_port_req_valid), .port_req_ready(1'b1), .port_addr(f_port_addr),
    .port_wen(f_port_wen), .port_wdata(f_port_wdata), .port_wstrb(f_port_wstrb),
    .port_resp_valid(1'b1), .port_resp_ready(f_port_resp_ready),
    .port_rdata(32'hCAFE_F00D), .conflict_cnt(f_conflict_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench-side memory: word array plus one outstanding read response.
  logic [31:0] mem [256];
  logic        resp_pend, resp_gate;
  logic [31:0] resp_data;
  assign port_resp_valid = resp_pend & resp_gate;
  assign port_rdata      = resp_data;

  // Transaction-level model: phase 0 = no transaction, 1 = issuing, 2 = awaiting data.
  int          m_phase, m_owner, m_last;
  logic        m_wen;
  logic [31:0] m_addr, m_wdata, m_cnt;
  logic [3:0]  m_wstrb;
  logic        g_inst_ack, g_mem_ack;
  logic        chk_en = 1'b0;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = 0; m_wen = 1'b0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0; m_cnt = '0;
  endtask

  // Advance memory and model across one rising edge using the pre-edge inputs.
  task automatic step();
    bit ip, dp;
    int g;
    @(posedge clk);
    #1;
    g_inst_ack = !rst && m_phase == 1 && m_owner == 0 && port_req_ready;
    g_mem_ack  = !rst && m_phase == 1 && m_owner == 1 && port_req_ready;
    if (rst) begin
      resp_pend = 1'b0;
      model_reset();
    end else if (m_phase == 1) begin
      if (port_req_ready) begin
        if (m_wen) begin
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) mem[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
          m_phase = 0;
        end else begin
          resp_pend = 1'b1;
          resp_data = mem[m_addr[9:2]];
          m_phase   = 2;
        end
      end
    end else if (m_phase == 2) begin
      if (port_resp_valid && ((m_owner == 0) ? inst_ready : read_data_ready)) begin
        resp_pend = 1'b0;
        m_phase   = 0;
      end
    end else begin
      ip = inst_req_valid;
      dp = mem_read | mem_write;
      if (ip || dp) begin
        if (ip && dp) begin
          m_cnt = m_cnt + 1;
          g = (RR != 0) ? ((m_last == 0) ? 1 : 0) : 1;
        end else begin
          g = dp ? 1 : 0;
        end
        m_owner = g;
        m_last  = g;
        if (g == 1) begin
          m_addr  = mem_addr;
          m_wen   = mem_write;
          m_wdata = mem_write ? mem_wdata : 32'h0;
          m_wstrb = mem_write ? mem_wstrb : 4'h0;
        end else begin
          m_addr = inst_addr; m_wen = 1'b0; m_wdata = '0; m_wstrb = '0;
        end
        m_phase = 1;
      end
    end
  endtask

  // Every cycle: derive required outputs from the model and current inputs, compare.
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_prv, e_irr, e_ack, e_iv, e_rv, e_prr;
      e_prv = (m_phase == 1);
      e_irr = (m_phase == 1) && (m_owner == 0) && port_req_ready;
      e_ack = (m_phase == 1) && (m_owner == 1) && port_req_ready;
      e_iv  = (m_phase == 2) && (m_owner == 0) && port_resp_valid;
      e_rv  = (m_phase == 2) && (m_owner == 1) && port_resp_valid;
      e_prr = (m_phase == 2) && ((m_owner == 0) ? inst_ready : read_data_ready);
      check("port_req_valid", port_req_valid, e_prv);
      check("inst_req_ready", inst_req_ready, e_irr);
      check("mem_req_ack", mem_req_ack, e_ack);
      check("inst_valid", inst_valid, e_iv);
      check("read_data_valid", read_data_valid, e_rv);
      check("port_resp_ready", port_resp_ready, e_prr);
      check("port_addr", port_addr, m_addr);
      check("port_wen", port_wen, m_wen);
      check("port_wdata", port_wdata, m_wdata);
      check("port_wstrb", port_wstrb, m_wstrb);
      check("conflict_cnt", conflict_cnt, m_cnt);
      if (e_iv) check("inst_rdata", inst_rdata, resp_data);
      if (e_rv) check("read_data", read_data, resp_data);
    end
  end

  task automatic rand_inputs();
    int r;
    if (g_inst_ack || !inst_req_valid) begin
      inst_req_valid = ($urandom_range(0, 99) < 50);
      inst_addr      = 32'($urandom_range(0, 255)) << 2;
    end
    if (g_mem_ack || !(mem_read || mem_write)) begin
      r = $urandom_range(0, 99);
      mem_read  = (r < 30) || (r >= 55 && r < 58);
      mem_write = (r >= 30 && r < 58);
      mem_addr  = 32'($urandom_range(0, 255)) << 2;
      mem_wdata = $urandom;
      mem_wstrb = 4'($urandom_range(0, 15));
    end
    inst_ready      = ($urandom_range(0, 3) != 0);
    read_data_ready = ($urandom_range(0, 3) != 0);
    port_req_ready  = ($urandom_range(0, 3) != 0);
    resp_gate       = ($urandom_range(0, 3) != 0);
    rst             = ($urandom_range(0, 199) == 0);
  endtask

  int f_acks;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;
    rst = 1'b1; f_rst = 1'b1;
    inst_req_valid = 0; inst_addr = '0; inst_ready = 0;
    mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    read_data_ready = 0; port_req_ready = 0; resp_gate = 0;
    resp_pend = 0; resp_data = '0; g_inst_ack = 0; g_mem_ack = 0;
    model_reset();
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst port_req_valid", port_req_valid, 0);
    check("rst port_addr", port_addr, 0);
    check("rst conflict_cnt", conflict_cnt, 0);
    check("rst inst_valid", inst_valid, 0);
    step(); rst = 1'b0;

    // Fetch only, zero-wait memory.
    inst_req_valid = 1; inst_addr = 32'h0; port_req_ready = 1; resp_gate = 1; inst_ready = 1;
    @(negedge clk); check("t1 cycle1 ready", inst_req_ready, 0); step();
    @(negedge clk); check("t1 cycle2 ready", inst_req_ready, 1); step(); inst_req_valid = 0;
    @(negedge clk); check("t1 cycle3 valid", inst_valid, 1);
    check("t1 cycle3 rdata", inst_rdata, 32'h0000_0013); step();

    // Store.
    mem_write = 1; mem_addr = 32'h0C; mem_wdata = 32'h0; mem_wstrb = 4'hF;
    @(negedge clk); step();
    @(negedge clk);
    check("t2 port_wen", port_wen, 1);
    check("t2 port_addr", port_addr, 32'h0C);
    check("t2 port_wstrb", port_wstrb, 4'hF);
    check("t2 ack", mem_req_ack, 1);
    step(); mem_write = 0;
    repeat (2) begin
      @(negedge clk);
      check("t2 no ack", mem_req_ack, 0);
      check("t2 no rdv", read_data_valid, 0);
      check("t2 no iv", inst_valid, 0);
      step();
    end

    // Simultaneous fetch and load after reset.
    rst = 1; step(); rst = 0;
    inst_req_valid = 1; inst_addr = 32'h100; mem_read = 1; mem_addr = 32'h200;
    read_data_ready = 1; inst_ready = 1;
    @(negedge clk); check("t3 cnt before", conflict_cnt, 0); step();
    @(negedge clk);
    check("t3 data first", mem_req_ack, 1);
    check("t3 inst waits", inst_req_ready, 0);
    check("t3 addr data", port_addr, 32'h200);
    check("t3 cnt", conflict_cnt, 1);
    step(); mem_read = 0;
    @(negedge clk); check("t3 load valid", read_data_valid, 1); step();
    @(negedge clk); check("t3 idle no ack", inst_req_ready, 0); step();
    @(negedge clk);
    check("t3 inst second", inst_req_ready, 1);
    check("t3 addr inst", port_addr, 32'h100);
    check("t3 cnt after", conflict_cnt, 1);
    step(); inst_req_valid = 0;
    @(negedge clk); check("t3 fetch valid", inst_valid, 1); step();

    // Memory backpressure then CPU backpressure on a fetch.
    inst_req_valid = 1; inst_addr = 32'h40; port_req_ready = 0; inst_ready = 0;
    @(negedge clk); step();
    repeat (5) begin
      @(negedge clk);
      check("t4 no ack", inst_req_ready, 0);
      check("t4 addr held", port_addr, 32'h40);
      check("t4 wen held", port_wen, 0);
      step();
    end
    port_req_ready = 1;
    @(negedge clk); check("t4 ack", inst_req_ready, 1); step(); inst_req_valid = 0;
    repeat (3) begin
      @(negedge clk);
      check("t5 resp_ready low", port_resp_ready, 0);
      check("t5 valid held", inst_valid, 1);
      step();
    end
    inst_ready = 1;
    @(negedge clk); check("t5 resp_ready", port_resp_ready, 1);
    check("t5 rdata", inst_rdata, mem[16]); step();
    @(negedge clk); check("t5 single transfer", inst_valid, 0); step();

    // Reset in the response phase.
    inst_req_valid = 1; inst_addr = 32'h0; inst_ready = 0;
    @(negedge clk); step();
    @(negedge clk); step(); inst_req_valid = 0; rst = 1;
    @(negedge clk); check("t6 in resp", inst_valid, 1); step(); rst = 0; inst_ready = 1;
    @(negedge clk);
    check("t6 iv cleared", inst_valid, 0);
    check("t6 prv cleared", port_req_valid, 0);
    check("t6 prr cleared", port_resp_ready, 0);
    check("t6 addr cleared", port_addr, 0);
    check("t6 cnt cleared", conflict_cnt, 0);
    inst_req_valid = 1; inst_addr = 32'h8;
    step();
    @(negedge clk); check("t6 refetch ack", inst_req_ready, 1); step(); inst_req_valid = 0;
    @(negedge clk); check("t6 refetch valid", inst_valid, 1);
    check("t6 refetch rdata", inst_rdata, mem[2]); step();

    // Randomized traffic against the model.
    repeat (3000) begin
      rand_inputs();
      step();
    end
    rst = 1; step(); step(); rst = 0;

    // Fixed priority: instruction side starves under a continuous load stream.
    f_rst = 0;
    f_acks = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("fix inst starved", f_inst_req_ready, 0);
      check("fix no inst resp", f_inst_valid, 0);
      if (f_mem_req_ack) f_acks++;
      if (k == 12) check("fix conflict_cnt", f_conflict_cnt, 4);
      step();
    end
    check("fix data acks", f_acks, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
